// File: rtl/hazard_sched.sv
// ============================================================================
// Module   : hazard_sched
// Function : Hazard/stall scheduler for a 5-stage pipeline (forwarding,
//            load-use stall, branch flush, post-reset flush, memory wait FSM).
//            Optional performance counters enabled with HAZARD_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_sched #(
    parameter int INIT_FLUSH  = 2,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        LoadE,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemAckM,
`ifdef HAZARD_PERF_EN
    input  logic        CntClr,
    output logic [31:0] LwStallCnt,
    output logic [31:0] FlushCnt,
    output logic [31:0] MemWaitCnt,
`endif
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemErr,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_RUN   = 2'b01,
        S_MWAIT = 2'b10,
        S_ERR   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] C_INIT_LAST = CNT_W'(INIT_FLUSH - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(MEM_TIMEOUT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic       w_active;
    logic       w_mem_stall;
    logic       w_lw_stall;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (RegWriteM && (RdM != 5'd0) && (src == RdM))
            return 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (src == RdW))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_active    = (r_state == S_RUN) || (r_state == S_MWAIT);
    assign w_mem_stall = w_active && MemReqM && !MemAckM;
    assign w_lw_stall  = LoadE && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
    assign w_fwd_a     = fwd_sel(Rs1E);
    assign w_fwd_b     = fwd_sel(Rs2E);

    // A memory stall freezes E, so branch/load-use flushes wait for the release.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        case (r_state)
            S_INIT: begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end
            S_RUN, S_MWAIT: begin
                StallF    = w_lw_stall | w_mem_stall;
                StallD    = w_lw_stall | w_mem_stall;
                StallE    = w_mem_stall;
                StallM    = w_mem_stall;
                FlushW    = w_mem_stall;
                FlushD    = PCSrcE & ~w_mem_stall;
                FlushE    = (w_lw_stall | PCSrcE) & ~w_mem_stall;
                ForwardAE = w_fwd_a;
                ForwardBE = w_fwd_b;
            end
            default: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_cnt == C_INIT_LAST) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_mem_stall) begin
                        r_state <= S_MWAIT;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_MWAIT: begin
                    if (MemAckM) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_TIMEOUT) begin
                        r_state <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_ERR;
            endcase
        end
    end

    assign State  = r_state;
    assign MemErr = (r_state == S_ERR);

`ifdef HAZARD_PERF_EN
    logic [31:0] r_lw_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lw_cnt    <= '0;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
        end else if (CntClr) begin
            r_lw_cnt    <= '0;
            r_flush_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            if ((r_state == S_RUN) && w_lw_stall && !w_mem_stall && !(&r_lw_cnt))
                r_lw_cnt <= r_lw_cnt + 1'b1;
            if (w_active && FlushD && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_mem_stall && !(&r_wait_cnt))
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign LwStallCnt = r_lw_cnt;
    assign FlushCnt   = r_flush_cnt;
    assign MemWaitCnt = r_wait_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_sched.sv
// ============================================================================
// Module   : tb_hazard_sched
// Function : Self-checking bench for hazard_sched (vector table, directed
//            multi-cycle sequences, randomized run against a reference model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_sched;

    localparam int TB_INIT = 2;
    localparam int TB_TO   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemAckM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [1:0]  ForwardAE, ForwardBE, State;
`ifdef HAZARD_PERF_EN
    logic        CntClr;
    logic [31:0] LwStallCnt, FlushCnt, MemWaitCnt;
    logic [31:0] m_lw, m_fl, m_mw;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int m_state;
    int m_cnt;

    logic [13:0] act;
    assign act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                  ForwardAE, ForwardBE, MemErr, State};

    hazard_sched #(.INIT_FLUSH(TB_INIT), .MEM_TIMEOUT(TB_TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemAckM(MemAckM),
`ifdef HAZARD_PERF_EN
        .CntClr(CntClr), .LwStallCnt(LwStallCnt), .FlushCnt(FlushCnt),
        .MemWaitCnt(MemWaitCnt),
`endif
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .State(State)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference model: expected outputs from the hazard rules
    function automatic logic [1:0] fwd(input logic [4:0] src);
        if (RegWriteM && RdM != 0 && src == RdM) return 2'b10;
        if (RegWriteW && RdW != 0 && src == RdW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic lw_hazard();
        return LoadE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
    endfunction

    function automatic logic mem_hazard();
        return (m_state == 1 || m_state == 2) && MemReqM && !MemAckM;
    endfunction

    function automatic logic [13:0] model_out();
        logic lw, ms;
        lw = lw_hazard();
        ms = mem_hazard();
        case (m_state)
            0:       return {4'b0000, 3'b110, 4'b0000, 1'b0, 2'b00};
            3:       return {4'b1111, 3'b001, 4'b0000, 1'b1, 2'b11};
            default: return {lw | ms, lw | ms, ms, ms, PCSrcE & ~ms,
                             (lw | PCSrcE) & ~ms, ms, fwd(Rs1E), fwd(Rs2E),
                             1'b0, 2'(m_state)};
        endcase
    endfunction

    task automatic model_step();
        logic lw, ms, fd;
        lw = lw_hazard();
        ms = mem_hazard();
        fd = (m_state == 1 || m_state == 2) && PCSrcE && !ms;
`ifdef HAZARD_PERF_EN
        if (CntClr) begin
            m_lw = 0; m_fl = 0; m_mw = 0;
        end else begin
            if (m_state == 1 && lw && !ms && m_lw != 32'hFFFFFFFF) m_lw = m_lw + 1;
            if (fd && m_fl != 32'hFFFFFFFF) m_fl = m_fl + 1;
            if (ms && m_mw != 32'hFFFFFFFF) m_mw = m_mw + 1;
        end
`else
        if (fd) begin end
`endif
        case (m_state)
            0: begin
                m_cnt++;
                if (m_cnt == TB_INIT) begin m_state = 1; m_cnt = 0; end
            end
            1: if (ms) begin m_state = 2; m_cnt = 1; end
            2: begin
                if (MemAckM)              m_state = 1;
                else if (m_cnt == TB_TO)  m_state = 3;
                else                      m_cnt++;
            end
            default: m_state = 3;
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_perf(input string name);
`ifdef HAZARD_PERF_EN
        check({name, "_lwcnt"}, LwStallCnt, m_lw);
        check({name, "_flcnt"}, FlushCnt, m_fl);
        check({name, "_mwcnt"}, MemWaitCnt, m_mw);
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    // Sample at negedge against the model, then advance one clock
    task automatic cycle(input string name);
        @(negedge clk);
        check(name, 32'(act), 32'(model_out()));
        check_perf(name);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0;
        MemReqM = 0; MemAckM = 0;
`ifdef HAZARD_PERF_EN
        CntClr = 0;
`endif
    endtask

    // Asynchronous reset asserted off-edge; released just after a rising edge
    task automatic apply_reset(input string name);
        reset = 1'b0;
        #2;
        m_state = 0;
        m_cnt   = 0;
`ifdef HAZARD_PERF_EN
        m_lw = 0; m_fl = 0; m_mw = 0;
`endif
        check(name, 32'(act), 32'({4'b0000, 3'b110, 4'b0000, 1'b0, 2'b00}));
        check_perf(name);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic        rwm, rww, lde, pcs, req, ack;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        clear_inputs();
        reset = 1'b0;
        m_state = 0;
        m_cnt = 0;
        #3;
        apply_reset("reset");

        // Post-reset flush window
        cycle("init0");
        cycle("init1");
        @(negedge clk);
        check("run_state", 32'(State), 32'(2'b01));

        //                rs1d rs2d rs1e rs2e rde rdm rdw rwm rww lde pcs req ack
        vecs[0] = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 1, 1, 0, 0, 0, 0,
                    {4'b0000, 3'b000, 2'b10, 2'b00, 1'b0, 2'b01}};
        vecs[1] = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 0, 1, 0, 0, 0, 0,
                    {4'b0000, 3'b000, 2'b01, 2'b00, 1'b0, 2'b01}};
        vecs[2] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0,
                    {4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 2'b01}};
        vecs[3] = '{5'd0, 5'd0, 5'd4, 5'd3, 5'd0, 5'd3, 5'd4, 1, 1, 0, 0, 0, 0,
                    {4'b0000, 3'b000, 2'b01, 2'b10, 1'b0, 2'b01}};
        vecs[4] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0,
                    {4'b1100, 3'b010, 2'b00, 2'b00, 1'b0, 2'b01}};
        vecs[5] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0,
                    {4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 2'b01}};
        vecs[6] = '{5'd1, 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0,
                    {4'b1100, 3'b010, 2'b00, 2'b00, 1'b0, 2'b01}};
        vecs[7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0,
                    {4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 2'b01}};
        vecs[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1,
                    {4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 2'b01}};
        vecs[9] = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd7, 5'd7, 0, 0, 0, 0, 0, 0,
                    {4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 2'b01}};

        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 10; i++) begin
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e;
            Rs2E = vecs[i].rs2e; RdE = vecs[i].rde; RdM = vecs[i].rdm;
            RdW = vecs[i].rdw; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            LoadE = vecs[i].lde; PCSrcE = vecs[i].pcs;
            MemReqM = vecs[i].req; MemAckM = vecs[i].ack;
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
            @(posedge clk);
            model_step();
            #1;
        end

        // Three wait cycles with a pending branch, released in the ack cycle
        clear_inputs();
        MemReqM = 1; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mwait%0d", i), 32'(act),
                  32'({4'b1111, 3'b001, 4'b0000, 1'b0, (i == 0) ? 2'b01 : 2'b10}));
            @(posedge clk);
            model_step();
            #1;
        end
        MemAckM = 1;
        @(negedge clk);
        check("mwait_ack", 32'(act), 32'({4'b0000, 3'b110, 4'b0000, 1'b0, 2'b10}));
        @(posedge clk);
        model_step();
        #1;
        clear_inputs();
        cycle("mwait_back_run");

        // Timeout into ERR, inputs ignored there, then reset recovers
        MemReqM = 1;
        for (int i = 0; i < 1 + TB_TO; i++) cycle("to_wait");
        @(negedge clk);
        check("err_state", 32'(act), 32'({4'b1111, 3'b001, 4'b0000, 1'b1, 2'b11}));
        for (int i = 0; i < 4; i++) begin
            MemAckM = 1'($urandom); PCSrcE = 1'($urandom); LoadE = 1;
            RdE = 5'd3; Rs1D = 5'd3;
            cycle("err_hold");
        end
        clear_inputs();
        apply_reset("err_reset");
        cycle("err_reinit0");
        cycle("err_reinit1");

        // Reset mid-access
        MemReqM = 1;
        cycle("pre_mid");
        cycle("mid_mwait");
        @(negedge clk);
        apply_reset("mid_reset");
        clear_inputs();
        cycle("mid_reinit0");
        cycle("mid_reinit1");

`ifdef HAZARD_PERF_EN
        CntClr = 1;
        cycle("pclr0");
        CntClr = 0;
        LoadE = 1; RdE = 5'd6; Rs2D = 5'd6;
        for (int i = 0; i < 3; i++) cycle("plw");
        clear_inputs();
        MemReqM = 1;
        for (int i = 0; i < 3; i++) cycle("pmw_a");
        MemAckM = 1;
        cycle("pmw_ack_a");
        MemAckM = 0;
        for (int i = 0; i < 2; i++) cycle("pmw_b");
        MemAckM = 1;
        cycle("pmw_ack_b");
        clear_inputs();
        @(negedge clk);
        check("perf_lw3", LwStallCnt, 32'd3);
        check("perf_mw5", MemWaitCnt, 32'd5);
        CntClr = 1;
        LoadE = 1; RdE = 5'd6; Rs2D = 5'd6; PCSrcE = 1;
        cycle("pclr1");
        clear_inputs();
        @(negedge clk);
        check("perf_clr", {LwStallCnt | FlushCnt | MemWaitCnt}, 32'd0);
`endif

        // Randomized run against the model
        for (int n = 0; n < 1500; n++) begin
            if (n % 300 == 299) begin
                @(negedge clk);
                apply_reset("rnd_reset");
            end
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            LoadE = 1'($urandom); PCSrcE = ($urandom_range(0, 3) == 0);
            MemReqM = 1'($urandom); MemAckM = ($urandom_range(0, 3) != 0);
`ifdef HAZARD_PERF_EN
            CntClr = ($urandom_range(0, 63) == 0);
`endif
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
